// File: rtl/pipe_stage_bank.sv
// rtl/pipe_stage_bank.sv - elastic valid/ready pipeline register bank with flush and reset value
// Optional occupancy output enabled by defining PIPE_STAGE_BANK_OCC_EN.
module pipe_stage_bank #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_STAGE_BANK_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
    $error("pipe_stage_bank: DEPTH and WIDTH must both be >= 1");
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] r;

  // A stage can load when it is empty or its own content moves on this cycle.
  always_comb begin
    logic run;
    run = out_ready;
    r   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      run  = !v[i] | run;
      r[i] = run;
    end
  end

  assign in_ready  = r[0] & !flush & rst;
  assign out_valid = v[DEPTH-1] & rst;
  assign out_data  = rst ? d[DEPTH-1] : RESET_VAL;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      if (r[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          d[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (r[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
          end
        end
      end
    end
  end

`ifdef PIPE_STAGE_BANK_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OW'(1);
    end else if (!in_xfer && out_xfer) begin
      occupancy <= occupancy - OW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_bank.sv
// tb/tb_pipe_stage_bank.sv - directed table plus randomized reference-model bench for pipe_stage_bank
module tb_pipe_stage_bank;

  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
`ifdef PIPE_STAGE_BANK_OCC_EN
  logic [$clog2(D+1)-1:0] occupancy;
`endif

  pipe_stage_bank #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_STAGE_BANK_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ir;
    int         e_occ;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [7:0] id,
                     input logic ordy, input logic e_ov, input logic [7:0] e_od,
                     input logic e_ir, input int e_occ);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = iv; t.id = id; t.ordy = ordy;
    t.e_ov = e_ov; t.e_od = e_od; t.e_ir = e_ir; t.e_occ = e_occ;
    tbl.push_back(t);
  endtask

  // reference model: slots hold words, words advance into free space from the output end
  bit         full [D];
  logic [7:0] word [D];
  bit         nf   [D];
  logic [7:0] nw   [D];
  logic [7:0] exp_q[$];
  logic       m_ov;
  logic       m_ir;
  int         cnt;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // reset
    add(0,0,0,8'h00,1, 0,8'hA5,0,0);
    add(0,0,0,8'h00,1, 0,8'hA5,0,0);
    add(1,0,0,8'h00,1, 0,8'hA5,1,0);
    // streaming
    add(1,0,1,8'h01,1, 0,8'hA5,1,0);
    add(1,0,1,8'h02,1, 0,8'hA5,1,1);
    add(1,0,1,8'h03,1, 0,8'hA5,1,2);
    add(1,0,0,8'h00,1, 1,8'h01,1,3);
    add(1,0,0,8'h00,1, 1,8'h02,1,2);
    add(1,0,0,8'h00,1, 1,8'h03,1,1);
    add(1,0,0,8'h00,1, 0,8'h03,1,0);
    // backpressure / full
    add(1,0,1,8'h10,0, 0,8'h03,1,0);
    add(1,0,1,8'h11,0, 0,8'h03,1,1);
    add(1,0,1,8'h12,0, 0,8'h03,1,2);
    add(1,0,1,8'h13,0, 1,8'h10,0,3);
    add(1,0,1,8'h13,1, 1,8'h10,1,3);
    add(1,0,0,8'h00,1, 1,8'h11,1,3);
    add(1,0,0,8'h00,1, 1,8'h12,1,2);
    add(1,0,0,8'h00,1, 1,8'h13,1,1);
    add(1,0,0,8'h00,1, 0,8'h13,1,0);
    // bubble collapse
    add(1,0,1,8'h20,0, 0,8'h13,1,0);
    add(1,0,0,8'h00,0, 0,8'h13,1,1);
    add(1,0,1,8'h21,0, 0,8'h13,1,1);
    add(1,0,0,8'h00,0, 1,8'h20,1,2);
    add(1,0,0,8'h00,0, 1,8'h20,1,2);
    // flush with three in flight
    add(1,0,1,8'h22,0, 1,8'h20,1,2);
    add(1,1,1,8'hFF,0, 1,8'h20,0,3);
    add(1,0,0,8'h00,1, 0,8'h20,1,0);
    add(1,0,1,8'h30,1, 0,8'h20,1,0);
    add(1,0,0,8'h00,1, 0,8'h20,1,1);
    add(1,0,0,8'h00,1, 0,8'h20,1,1);
    add(1,0,0,8'h00,1, 1,8'h30,1,1);
    add(1,0,0,8'h00,1, 0,8'h30,1,0);
    // mid-operation reset on a full bank
    add(1,0,1,8'h40,0, 0,8'h30,1,0);
    add(1,0,1,8'h41,0, 0,8'h30,1,1);
    add(1,0,1,8'h42,0, 0,8'h30,1,2);
    add(1,0,0,8'h00,0, 1,8'h40,0,3);
    add(0,0,1,8'h43,1, 0,8'hA5,0,3);
    add(1,0,0,8'h00,1, 0,8'hA5,1,0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; flush = tbl[k].flush; in_valid = tbl[k].iv;
      in_data = tbl[k].id; out_ready = tbl[k].ordy;
      @(negedge clk);
      check($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
      check($sformatf("vec%0d out_data", k), 32'(out_data), 32'(tbl[k].e_od));
      check($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(tbl[k].e_ir));
`ifdef PIPE_STAGE_BANK_OCC_EN
      check($sformatf("vec%0d occupancy", k), 32'(occupancy), 32'(tbl[k].e_occ));
`endif
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < D; i++) begin
      full[i] = 1'b0;
      word[i] = RV;
    end

    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst       = (cyc == 0) ? 1'b0 : ($urandom_range(63) != 0);
      flush     = ($urandom_range(31) == 0);
      in_valid  = ($urandom_range(9) < 7);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(9) < 6);
      @(negedge clk);

      for (int i = 0; i < D; i++) begin
        nf[i] = full[i];
        nw[i] = word[i];
      end
      m_ov = rst && full[D-1];
      if (rst) begin
        if (full[D-1] && out_ready) nf[D-1] = 1'b0;
        for (int i = D - 2; i >= 0; i--) begin
          if (nf[i] && !nf[i+1]) begin
            nf[i+1] = 1'b1;
            nw[i+1] = nw[i];
            nf[i]   = 1'b0;
          end
        end
      end
      m_ir = rst && !flush && !nf[0];

      check("rnd out_valid", 32'(out_valid), 32'(m_ov));
      check("rnd in_ready", 32'(in_ready), 32'(m_ir));
      if (m_ov) check("rnd out_data", 32'(out_data), 32'(word[D-1]));
      if (!rst) check("rnd reset out_data", 32'(out_data), 32'(RV));
      if (m_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd delivery without pending word", 32'(1), 32'(0));
        end else begin
          check("rnd fifo order", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
`ifdef PIPE_STAGE_BANK_OCC_EN
      cnt = 0;
      for (int i = 0; i < D; i++) cnt += int'(full[i]);
      check("rnd occupancy", 32'(occupancy), 32'(cnt));
`endif

      if (!rst) begin
        for (int i = 0; i < D; i++) begin
          full[i] = 1'b0;
          word[i] = RV;
        end
        exp_q.delete();
      end else if (flush) begin
        for (int i = 0; i < D; i++) full[i] = 1'b0;
        exp_q.delete();
      end else begin
        for (int i = 0; i < D; i++) begin
          full[i] = nf[i];
          word[i] = nw[i];
        end
        if (in_valid && m_ir) begin
          full[0] = 1'b1;
          word[0] = in_data;
          exp_q.push_back(in_data);
        end
      end

      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
